// File: rtl/dec32_pkg.sv
// Shared definitions for the decimal32 multiplier result path: flag bit
// positions, the canonical quiet NaN and the queued entry layout.
package dec32_pkg;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    localparam logic [31:0] DEC32_QNAN    = 32'h7C00_0000;
    localparam int          DEC32_ENTRY_W = 36;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
    } dec32_entry_t;

    // Invalid-operation products are replaced by the positive canonical qNaN.
    function automatic logic [31:0] canon_result(input logic [31:0] result,
                                                 input logic [3:0]  flags);
        return flags[FLAG_INVALID] ? DEC32_QNAN : result;
    endfunction

endpackage

// File: rtl/dec32_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter so full and empty
// never alias; ready/valid depend only on registered state.
module dec32_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 36
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign in_ready  = (count_r != FULL_CNT);
    assign out_valid = (count_r != {(AW+1){1'b0}});
    assign push_ok_s = push & in_ready;
    assign pop_ok_s  = pop & out_valid;
    assign rd_data   = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dec32_mul_result_queue.sv
// Result queue behind the decimal32 multiplier: canonicalises invalid results,
// buffers products and keeps sticky exception flags with a maskable trap.
module dec32_mul_result_queue
    import dec32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_result,
    input  logic [3:0]    in_flags,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_result,
    output logic [3:0]    out_flags,
    output logic [AW:0]   count,
    input  logic [3:0]    flag_mask,
    input  logic          sticky_clear,
    output logic [3:0]    sticky_flags,
    output logic          trap
);

    dec32_entry_t wr_entry_s;
    dec32_entry_t rd_entry_s;
    logic         accept_s;
    logic [3:0]   sticky_next_s;
    logic [3:0]   sticky_r;
    logic         trap_r;

    dec32_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (DEC32_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .wr_data   (wr_entry_s),
        .pop       (out_ready),
        .rd_data   (rd_entry_s),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .count     (count)
    );

    assign accept_s     = in_valid & in_ready;
    assign out_result   = rd_entry_s.result;
    assign out_flags    = rd_entry_s.flags;
    assign sticky_flags = sticky_r;
    assign trap         = trap_r;

    // Entry formation and next sticky value; a clear loses to a same-cycle accept.
    always_comb begin
        wr_entry_s.result = canon_result(in_result, in_flags);
        wr_entry_s.flags  = in_flags;
        sticky_next_s     = sticky_r;
        if (sticky_clear) begin
            sticky_next_s = 4'b0000;
        end else begin
            sticky_next_s = sticky_r;
        end
        if (accept_s) begin
            sticky_next_s = sticky_next_s | in_flags;
        end else begin
            sticky_next_s = sticky_next_s;
        end
    end

    // Sticky flags and the registered trap derived from them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_r <= 4'b0000;
            trap_r   <= 1'b0;
        end else begin
            sticky_r <= sticky_next_s;
            trap_r   <= |(sticky_next_s & ~flag_mask);
        end
    end

endmodule

// File: tb/tb_dec32_mul_result_queue.sv
// Scoreboard bench: driver updates a queue-based reference model each edge,
// a negedge monitor checks status and compares head entries against it.
module tb_dec32_mul_result_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic [2:0]  count;
    logic [3:0]  flag_mask;
    logic        sticky_clear;
    logic [3:0]  sticky_flags;
    logic        trap;

    int          total = 0;
    int          bad   = 0;
    logic [35:0] exp_q [$];
    int          mcount;
    logic [3:0]  msticky;
    logic        mtrap;
    logic        mon_en = 1'b0;
    logic        last_acc;

    always #5 clk = ~clk;

    dec32_mul_result_queue dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .count        (count),
        .flag_mask    (flag_mask),
        .sticky_clear (sticky_clear),
        .sticky_flags (sticky_flags),
        .trap         (trap)
    );

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock edge; the model applies the rules to the inputs seen at that edge.
    task automatic step();
        logic       acc;
        logic       tk;
        logic [3:0] sn;
        @(posedge clk);
        if (rst) begin
            mcount  = 0;
            exp_q.delete();
            msticky = 4'b0000;
            mtrap   = 1'b0;
            acc     = 1'b0;
        end else begin
            acc = in_valid && (mcount != 4);
            tk  = out_ready && (mcount != 0);
            sn  = (sticky_clear ? 4'b0000 : msticky) | (acc ? in_flags : 4'b0000);
            msticky = sn;
            mtrap   = |(sn & ~flag_mask);
            if (acc)
                exp_q.push_back({(in_flags[3] ? 32'h7C00_0000 : in_result), in_flags});
            mcount = mcount + (acc ? 1 : 0) - (tk ? 1 : 0);
        end
        last_acc = acc;
        #1;
    endtask

    // Monitor: status every cycle, head entry whenever valid, pop on take.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 36'(count), 36'(mcount));
            chk("in_ready", 36'(in_ready), 36'(mcount != 4));
            chk("out_valid", 36'(out_valid), 36'(mcount != 0));
            chk("sticky", 36'(sticky_flags), 36'(msticky));
            chk("trap", 36'(trap), 36'(mtrap));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL head actual=%h required=none", {out_result, out_flags});
                end else begin
                    chk("head", {out_result, out_flags}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        out_ready = 1'b0;
    endtask

    task automatic push1(input logic [31:0] r, input logic [3:0] f);
        in_valid  = 1'b1;
        in_result = r;
        in_flags  = f;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_result = 32'h0; in_flags = 4'h0;
        out_ready = 1'b0; flag_mask = 4'h0; sticky_clear = 1'b0;
        mcount = 0; msticky = 4'h0; mtrap = 1'b0; last_acc = 1'b0;
        step(); step();
        mon_en = 1'b1;
        chk("rst_out_result", 36'(out_result), 36'h0);
        chk("rst_out_flags", 36'(out_flags), 36'h0);
        chk("rst_count", 36'(count), 36'h0);
        rst = 1'b0;

        // T1: single push, visible after the accepting edge
        push1(32'h2250_0012, 4'b0000);
        chk("t1_result", 36'(out_result), 36'h0_2250_0012);
        chk("t1_count", 36'(count), 36'd1);
        drain();

        // T2: overfill by one, 5th held until a pop frees a slot
        for (int k = 0; k < 4; k++) push1(32'h1000_0000 + 32'(k), 4'b0000);
        in_valid = 1'b1; in_result = 32'h1000_0004; in_flags = 4'b0000;
        for (int n = 0; n < 3; n++) step();
        chk("t2_full_ready", 36'(in_ready), 36'h0);
        out_ready = 1'b1; step();
        chk("t2_no_accept_when_full", 36'(last_acc), 36'h0);
        out_ready = 1'b0; step();
        chk("t2_count_after_refill", 36'(count), 36'd4);
        drain();

        // T3: invalid canonicalisation
        push1(32'hFFFF_FFFF, 4'b1000);
        chk("t3_result", 36'(out_result), 36'h0_7C00_0000);
        chk("t3_flags", 36'(out_flags), 36'h8);
        drain();

        // T4: masking, trap, clear coincident with accept
        sticky_clear = 1'b1; step(); sticky_clear = 1'b0;
        flag_mask = 4'b1110;
        push1(32'h2238_0001, 4'b0001);
        chk("t4_sticky", 36'(sticky_flags), 36'h1);
        chk("t4_trap", 36'(trap), 36'h1);
        sticky_clear = 1'b1;
        push1(32'h2238_0002, 4'b0100);
        sticky_clear = 1'b0;
        chk("t4_clear_sticky", 36'(sticky_flags), 36'h4);
        chk("t4_clear_trap", 36'(trap), 36'h0);
        flag_mask = 4'b0000; step();
        chk("t4_unmask_trap", 36'(trap), 36'h1);
        drain();

        // T5: streaming push+pop at count=2 across pointer wraps
        push1(32'h3000_0000, 4'b0000);
        push1(32'h3000_0001, 4'b0000);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            in_result = $urandom;
            in_flags  = 4'($urandom_range(0, 7));
            step();
        end
        chk("t5_count", 36'(count), 36'd2);
        drain();

        // T6: reset mid-stream with entries and sticky flags present
        sticky_clear = 1'b1; step(); sticky_clear = 1'b0;
        push1(32'h4000_0001, 4'b0010);
        push1(32'h4000_0002, 4'b0100);
        push1(32'h4000_0003, 4'b0000);
        chk("t6_pre_sticky", 36'(sticky_flags), 36'h6);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_count", 36'(count), 36'h0);
        chk("t6_valid", 36'(out_valid), 36'h0);
        chk("t6_sticky", 36'(sticky_flags), 36'h0);
        chk("t6_trap", 36'(trap), 36'h0);
        chk("t6_ready", 36'(in_ready), 36'h1);

        // Random traffic; data held stable while stalled
        for (int n = 0; n < 600; n++) begin
            if (!(in_valid && mcount == 4)) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_result = $urandom;
                in_flags  = 4'($urandom_range(0, 15)) & (($urandom_range(0, 3) == 0) ? 4'hF : 4'h1);
            end
            out_ready    = 1'($urandom_range(0, 2) != 0);
            flag_mask    = 4'($urandom_range(0, 15));
            sticky_clear = ($urandom_range(0, 15) == 0);
            step();
        end
        sticky_clear = 1'b0;
        drain();
        chk("end_empty", 36'(exp_q.size()), 36'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
